// File: rtl/pipe_pkg.sv
// Shared constants for the elastic pipeline stages: default payload geometry,
// occupancy encoding and the field layout of a D->E slot.
package pipe_pkg;

    localparam int unsigned NUM_FIELDS_DEF = 6;
    localparam int unsigned FIELD_W_DEF    = 32;

    localparam int unsigned OCC_W = 2;

    localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
    localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
    localparam logic [OCC_W-1:0] OCC_FULL  = 2'd2;

    localparam int unsigned F_INSTR = 0;
    localparam int unsigned F_RS    = 1;
    localparam int unsigned F_RT    = 2;
    localparam int unsigned F_EXT   = 3;
    localparam int unsigned F_PC8   = 4;
    localparam int unsigned F_S     = 5;

    // Default D->E slot; the first member lands in the top bits, so F_INSTR is lowest.
    typedef struct packed {
        logic [FIELD_W_DEF-1:0] s;
        logic [FIELD_W_DEF-1:0] pc8;
        logic [FIELD_W_DEF-1:0] ext;
        logic [FIELD_W_DEF-1:0] rt;
        logic [FIELD_W_DEF-1:0] rs;
        logic [FIELD_W_DEF-1:0] instr;
    } de_slot_t;

endpackage

// File: rtl/pipe_slot_reg.sv
// One payload slot: valid flag plus data word, with clear taking priority over load.
// Data is zeroed whenever the slot is invalid so empty slots read as nop bubbles.
module pipe_slot_reg #(
    parameter int unsigned WIDTH = 192
) (
    input  logic             clk,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register with a main slot and a skid slot (valid/ready, FIFO order).
// Optional stall/bubble counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_FIELDS = NUM_FIELDS_DEF,
    parameter int unsigned FIELD_W    = FIELD_W_DEF,
    localparam int unsigned PAYLOAD_W = NUM_FIELDS * FIELD_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [OCC_W-1:0]     occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          bubble_cnt
`endif
);

    logic [OCC_W-1:0]     occ_q;
    logic [OCC_W-1:0]     occ_d;
    logic                 main_v;
    logic                 skid_v;
    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] skid_q;
    logic [PAYLOAD_W-1:0] main_nxt;
    logic                 main_load;
    logic                 main_clr;
    logic                 skid_load;
    logic                 skid_clr;
    logic                 push;
    logic                 pop;

    // Ready depends only on the skid register, never on out_ready.
    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign out_data  = main_q;
    assign occupancy = occ_q;

    assign push = in_valid && !skid_v;
    assign pop  = main_v && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q <= OCC_EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    always_comb begin
        occ_d     = occ_q;
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        main_nxt  = in_data;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
            occ_d    = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (push) begin
                        main_load = 1'b1;
                        occ_d     = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (push) begin
                        skid_load = 1'b1;
                        occ_d     = OCC_FULL;
                    end else if (pop) begin
                        main_clr = 1'b1;
                        occ_d    = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // Skid slot advances into main; upstream is held off this cycle.
                    if (pop) begin
                        main_load = 1'b1;
                        main_nxt  = skid_q;
                        skid_clr  = 1'b1;
                        occ_d     = OCC_ONE;
                    end
                end
                default: begin
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                    occ_d    = OCC_EMPTY;
                end
            endcase
        end
    end

    pipe_slot_reg #(
        .WIDTH (PAYLOAD_W)
    ) u_main (
        .clk     (clk),
        .rst_n_i (reset),
        .load_i  (main_load),
        .clear_i (main_clr),
        .data_i  (main_nxt),
        .valid_o (main_v),
        .data_o  (main_q)
    );

    pipe_slot_reg #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk     (clk),
        .rst_n_i (reset),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .data_i  (in_data),
        .valid_o (skid_v),
        .data_o  (skid_q)
    );

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] stall_q;
    logic [31:0] stall_d;
    logic [31:0] bubble_q;
    logic [31:0] bubble_d;

    // Saturating counters; flush deliberately leaves them alone.
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (main_v && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + 32'd1;
        end
        if (!main_v && (bubble_q != CNT_MAX)) begin
            bubble_d = bubble_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, async-reset and
// counter sequences, then random traffic against a queue-based reference model.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int unsigned NF = NUM_FIELDS_DEF;
    localparam int unsigned FW = FIELD_W_DEF;
    localparam int unsigned PW = NF * FW;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   bubble_cnt;
`endif

    pipe_stage_skid dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [31:0] w;
        logic        ov;
        logic [31:0] ew;
        logic [1:0]  occ;
        logic        ir;
    } vec_t;

    vec_t          tbl[$];
    logic [PW-1:0] mq[$];
    logic [31:0]   m_stall;
    logic [31:0]   m_bubble;
    int            n_checks = 0;
    int            n_pass   = 0;

    function automatic logic [PW-1:0] mkp(input logic [31:0] w);
        logic [PW-1:0] p;
        p = '0;
        for (int k = 0; k < int'(NF); k++) begin
            p[k*FW +: FW] = w + 32'(k) * 32'h0101_0101;
        end
        return p;
    endfunction

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [PW-1:0] ed;
        ed = (mq.size() > 0) ? mq[0] : '0;
        chk({tag, ".out_valid"}, PW'(out_valid), PW'(mq.size() > 0));
        chk({tag, ".out_data"}, out_data, ed);
        chk({tag, ".occupancy"}, PW'(occupancy), PW'(mq.size()));
        chk({tag, ".in_ready"}, PW'(in_ready), PW'(mq.size() < 2));
    endtask

    // Reference: a 2-deep FIFO; flush empties it, push is accepted only with room.
    task automatic model_edge();
        int n;
        n = mq.size();
        if (n > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (n == 0 && m_bubble != 32'hFFFF_FFFF) m_bubble++;
        if (flush) begin
            mq.delete();
        end else begin
            if (n > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && n < 2) mq.push_back(in_data);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_stall  = '0;
        m_bubble = '0;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_edge();
        #1;
    endtask

    task automatic drive(input logic fl, input logic iv, input logic ordy, input logic [31:0] w);
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        in_data   = mkp(w);
    endtask

    task automatic add(input logic fl, input logic iv, input logic ordy, input logic [31:0] w,
                       input logic ov, input logic [31:0] ew, input logic [1:0] occ,
                       input logic ir);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ordy = ordy; v.w = w;
        v.ov = ov; v.ew = ew; v.occ = occ; v.ir = ir;
        tbl.push_back(v);
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        model_reset();
        #1;
    endtask

    initial begin
        int thr;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        model_reset();

        // Stream after reset
        add(1'b0, 1'b1, 1'b1, 32'h8C08_0004, 1'b1, 32'h8C08_0004, 2'd1, 1'b1);
        add(1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         2'd0, 1'b1);
        // Back-pressure: A,B fill, C held off, then drain in order
        add(1'b0, 1'b1, 1'b0, 32'h1, 1'b1, 32'h1, 2'd1, 1'b1);
        add(1'b0, 1'b1, 1'b0, 32'h2, 1'b1, 32'h1, 2'd2, 1'b0);
        add(1'b0, 1'b1, 1'b0, 32'h3, 1'b1, 32'h1, 2'd2, 1'b0);
        add(1'b0, 1'b1, 1'b1, 32'h3, 1'b1, 32'h2, 2'd1, 1'b1);
        add(1'b0, 1'b1, 1'b1, 32'h3, 1'b1, 32'h3, 2'd1, 1'b1);
        add(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 2'd0, 1'b1);
        // Flush in FULL with a competing push of D=4
        add(1'b0, 1'b1, 1'b0, 32'hA, 1'b1, 32'hA, 2'd1, 1'b1);
        add(1'b0, 1'b1, 1'b0, 32'hB, 1'b1, 32'hA, 2'd2, 1'b0);
        add(1'b1, 1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 2'd0, 1'b1);
        add(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 2'd0, 1'b1);
        // Simultaneous push/pop in ONE
        add(1'b0, 1'b1, 1'b0, 32'h5, 1'b1, 32'h5, 2'd1, 1'b1);
        add(1'b0, 1'b1, 1'b1, 32'h6, 1'b1, 32'h6, 2'd1, 1'b1);
        add(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 2'd0, 1'b1);
        // Flush drops a push even when ready; flush in ONE with a pop
        add(1'b1, 1'b1, 1'b1, 32'h7, 1'b0, 32'h0, 2'd0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 32'h8, 1'b1, 32'h8, 2'd1, 1'b1);
        add(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 2'd0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk_model("reset");
`ifdef PIPE_STAGE_PERF_EN
        chk("reset.stall_cnt", PW'(stall_cnt), PW'(32'd0));
        chk("reset.bubble_cnt", PW'(bubble_cnt), PW'(32'd0));
`endif
        reset = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].w);
            step();
            chk($sformatf("vec%0d.out_valid", i), PW'(out_valid), PW'(tbl[i].ov));
            chk($sformatf("vec%0d.out_data", i), out_data, tbl[i].ov ? mkp(tbl[i].ew) : '0);
            chk($sformatf("vec%0d.occupancy", i), PW'(occupancy), PW'(tbl[i].occ));
            chk($sformatf("vec%0d.in_ready", i), PW'(in_ready), PW'(tbl[i].ir));
        end

        // Async reset between edges while FULL
        drive(1'b0, 1'b1, 1'b0, 32'h11);
        step();
        drive(1'b0, 1'b1, 1'b0, 32'h22);
        step();
        chk("pre_arst.occupancy", PW'(occupancy), PW'(2'd2));
        async_reset();
        chk("arst.out_valid", PW'(out_valid), PW'(1'b0));
        chk("arst.out_data", out_data, '0);
        chk("arst.occupancy", PW'(occupancy), PW'(2'd0));
        chk("arst.in_ready", PW'(in_ready), PW'(1'b1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 32'h8C08_0004);
        step();
        chk("post_arst.out_valid", PW'(out_valid), PW'(1'b1));
        chk("post_arst.out_data", out_data, mkp(32'h8C08_0004));
        chk("post_arst.occupancy", PW'(occupancy), PW'(2'd1));
        chk("post_arst.in_ready", PW'(in_ready), PW'(1'b1));
        drive(1'b0, 1'b0, 1'b1, 32'h0);
        step();
        chk_model("post_arst.drain");

`ifdef PIPE_STAGE_PERF_EN
        // Counters: 1 empty cycle, 4 stalled, 1 pop, 3 empty, then flush with a pop
        async_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h33);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (4) step();
        drive(1'b0, 1'b0, 1'b1, 32'h0);
        step();
        repeat (3) step();
        chk("perf.stall_cnt", PW'(stall_cnt), PW'(32'd4));
        chk("perf.bubble_cnt", PW'(bubble_cnt), PW'(32'd4));
        drive(1'b0, 1'b1, 1'b1, 32'h44);
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h0);
        step();
        chk("perf_flush.stall_cnt", PW'(stall_cnt), PW'(32'd4));
        chk("perf_flush.bubble_cnt", PW'(bubble_cnt), PW'(32'd5));
        chk("perf_flush.occupancy", PW'(occupancy), PW'(2'd0));
`endif

        // Random traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            if (c % 100 == 0) thr = (c / 100) % 3 == 0 ? 25 : ((c / 100) % 3 == 1 ? 60 : 95);
            drive(1'($urandom_range(15) == 0), 1'($urandom_range(1)),
                  1'($urandom_range(99) < thr), 32'($urandom()));
            step();
            chk_model($sformatf("rand%0d", c));
`ifdef PIPE_STAGE_PERF_EN
            if (c % 50 == 49) begin
                chk($sformatf("rand%0d.stall_cnt", c), PW'(stall_cnt), PW'(m_stall));
                chk($sformatf("rand%0d.bubble_cnt", c), PW'(bubble_cnt), PW'(m_bubble));
            end
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
